// File: rtl/fu_op_sequencer.sv
// rtl/fu_op_sequencer.sv - issue sequencer between decode and the combinational function unit
//
// Accepts one operation at a time over a request valid/ready handshake,
// presents registered operands to the function unit, waits FU_LAT cycles for
// the unit to settle, then captures its result and flags. The result goes back
// over a response valid/ready handshake, and the status register is updated
// when the operation asks for it.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_fs/a/b/sh            function select, operands, shift amount
//   req_fwd_a                use the last completed result as operand A
//   req_setflags             let this operation update the status register
//   req_tag                  destination tag, returned with the result
//   fu_a/b/fs/sh             registered drive to the function unit
//   fu_f, fu_v/c/n/z         function unit result and flags
//   rsp_valid/rsp_ready      response handshake
//   rsp_f, rsp_tag, rsp_err  captured result, tag, illegal-code flag
//   sts_v/c/n/z              architectural status register

module fu_op_sequencer #(
    parameter int FU_LAT = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_fs,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [4:0]       req_sh,
    input  logic             req_fwd_a,
    input  logic             req_setflags,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fu_a,
    output logic [31:0]      fu_b,
    output logic [3:0]       fu_fs,
    output logic [4:0]       fu_sh,
    input  logic [31:0]      fu_f,
    input  logic             fu_v,
    input  logic             fu_c,
    input  logic             fu_n,
    input  logic             fu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_f,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             sts_v,
    output logic             sts_c,
    output logic             sts_n,
    output logic             sts_z
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] LAT = 3'(FU_LAT);

    logic [1:0]       state;
    logic [2:0]       cnt;
    logic [31:0]      last_f;
    logic [TAG_W-1:0] tag_q;
    logic             setflags_q;
    logic             fs_illegal;

    // Legality is judged on the registered code actually driven to the unit.
    always_comb begin
        fs_illegal = 1'b1;
        case (fu_fs)
            4'b0000, 4'b0010, 4'b0101, 4'b1000, 4'b1001,
            4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110: fs_illegal = 1'b0;
            default:                                     fs_illegal = 1'b1;
        endcase
    end

    // Held low while reset is asserted so nothing is offered during reset.
    assign req_ready = (state == S_IDLE) && !rst;
    assign rsp_valid = (state == S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            fu_a       <= 32'd0;
            fu_b       <= 32'd0;
            fu_fs      <= 4'd0;
            fu_sh      <= 5'd0;
            last_f     <= 32'd0;
            tag_q      <= '0;
            setflags_q <= 1'b0;
            rsp_f      <= 32'd0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
            sts_v      <= 1'b0;
            sts_c      <= 1'b0;
            sts_n      <= 1'b0;
            sts_z      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        fu_a       <= req_fwd_a ? last_f : req_a;
                        fu_b       <= req_b;
                        fu_fs      <= req_fs;
                        fu_sh      <= req_sh;
                        tag_q      <= req_tag;
                        setflags_q <= req_setflags;
                        cnt        <= LAT;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        rsp_f   <= fu_f;
                        last_f  <= fu_f;
                        rsp_tag <= tag_q;
                        rsp_err <= fs_illegal;
                        if (setflags_q && !fs_illegal) begin
                            sts_v <= fu_v;
                            sts_c <= fu_c;
                            sts_n <= fu_n;
                            sts_z <= fu_z;
                        end
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fu_op_sequencer.sv
// tb/tb_fu_op_sequencer.sv - directed vector bench for fu_op_sequencer

module tb_fu_op_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_fs;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_sh;
    logic        req_fwd_a;
    logic        req_setflags;
    logic [4:0]  req_tag;
    logic [31:0] fu_a, fu_b, fu_f;
    logic [3:0]  fu_fs;
    logic [4:0]  fu_sh;
    logic        fu_v, fu_c, fu_n, fu_z;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_f;
    logic [4:0]  rsp_tag;
    logic        sts_v, sts_c, sts_n, sts_z;

    logic        rst2, req_valid2, req_ready2, rsp_valid2, rsp_ready2, rsp_err2;
    logic [31:0] fu_a2, fu_b2, fu_f2, rsp_f2;
    logic [3:0]  fu_fs2;
    logic [4:0]  fu_sh2, rsp_tag2;
    logic        fu_v2, fu_c2, fu_n2, fu_z2;
    logic        sts_v2, sts_c2, sts_n2, sts_z2;

    int vectors;
    int miscompares;

    typedef struct {
        logic [3:0]  fs;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        fwd;
        logic        sf;
        logic [4:0]  tag;
        logic [31:0] exp_fu_a;
        logic [31:0] exp_f;
        logic        exp_err;
        logic [3:0]  exp_sts;   // {v,c,n,z}
    } vec_t;

    vec_t vecs[14];

    // Reference function unit: returns {v,c,n,z,f}.
    function automatic logic [35:0] fu_calc(input logic [3:0] fs, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        logic [32:0] s;
        logic [31:0] f;
        logic        v, c;
        s = 33'd0;
        v = 1'b0;
        c = 1'b0;
        case (fs)
            4'b0000: f = a;
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                f = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (f[31] != a[31]);
            end
            4'b0101: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                f = s[31:0];
                c = s[32];
                v = (a[31] != b[31]) && (f[31] != a[31]);
            end
            4'b1000: f = a & b;
            4'b1001: f = a | b;
            4'b1010: f = a ^ b;
            4'b1011: f = ~a;
            4'b1100: f = a << sh;
            4'b1101: f = a >> sh;
            4'b1110: f = b;
            default: f = a + b;
        endcase
        return {v, c, f[31], (f == 32'd0), f};
    endfunction

    assign {fu_v, fu_c, fu_n, fu_z, fu_f}     = fu_calc(fu_fs, fu_a, fu_b, fu_sh);
    assign {fu_v2, fu_c2, fu_n2, fu_z2, fu_f2} = fu_calc(fu_fs2, fu_a2, fu_b2, fu_sh2);

    fu_op_sequencer #(.FU_LAT(1), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fs(req_fs), .req_a(req_a), .req_b(req_b), .req_sh(req_sh),
        .req_fwd_a(req_fwd_a), .req_setflags(req_setflags), .req_tag(req_tag),
        .fu_a(fu_a), .fu_b(fu_b), .fu_fs(fu_fs), .fu_sh(fu_sh),
        .fu_f(fu_f), .fu_v(fu_v), .fu_c(fu_c), .fu_n(fu_n), .fu_z(fu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_f(rsp_f), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .sts_v(sts_v), .sts_c(sts_c), .sts_n(sts_n), .sts_z(sts_z)
    );

    fu_op_sequencer #(.FU_LAT(4), .TAG_W(5)) dut4 (
        .clk(clk), .rst(rst2),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_fs(req_fs), .req_a(req_a), .req_b(req_b), .req_sh(req_sh),
        .req_fwd_a(req_fwd_a), .req_setflags(req_setflags), .req_tag(req_tag),
        .fu_a(fu_a2), .fu_b(fu_b2), .fu_fs(fu_fs2), .fu_sh(fu_sh2),
        .fu_f(fu_f2), .fu_v(fu_v2), .fu_c(fu_c2), .fu_n(fu_n2), .fu_z(fu_z2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_f(rsp_f2), .rsp_tag(rsp_tag2), .rsp_err(rsp_err2),
        .sts_v(sts_v2), .sts_c(sts_c2), .sts_n(sts_n2), .sts_z(sts_z2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] fs, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic fwd, input logic sf,
                         input logic [4:0] tag);
        req_fs       = fs;
        req_a        = a;
        req_b        = b;
        req_sh       = sh;
        req_fwd_a    = fwd;
        req_setflags = sf;
        req_tag      = tag;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        @(negedge clk);
        check($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
        drive(v.fs, v.a, v.b, v.sh, v.fwd, v.sf, v.tag);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check($sformatf("v%0d fu_a", idx), fu_a, v.exp_fu_a);
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("v%0d latency", idx), 32'(cyc), 32'd2);
        check($sformatf("v%0d rsp_f", idx), rsp_f, v.exp_f);
        check($sformatf("v%0d rsp_tag", idx), 32'(rsp_tag), 32'(v.tag));
        check($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
        check($sformatf("v%0d sts", idx), 32'({sts_v, sts_c, sts_n, sts_z}), 32'(v.exp_sts));
    endtask

    initial begin
        logic [31:0] held_f;
        logic [4:0]  held_tag;
        int          cyc;
        int          seen;

        vectors     = 0;
        miscompares = 0;

        //           fs       a             b             sh  fwd sf tag fu_a          f             err sts
        vecs[0]  = '{4'b0000, 32'h1234,     32'd0,        5'd0, 1, 0, 1,  32'd0,        32'd0,        0, 4'b0000};
        vecs[1]  = '{4'b0010, 32'd5,        32'd7,        5'd0, 0, 1, 3,  32'd5,        32'd12,       0, 4'b0000};
        vecs[2]  = '{4'b0101, 32'd3,        32'd3,        5'd0, 0, 1, 4,  32'd3,        32'd0,        0, 4'b0101};
        vecs[3]  = '{4'b1001, 32'hF0,       32'h0F,       5'd0, 0, 0, 5,  32'hF0,       32'hFF,       0, 4'b0101};
        vecs[4]  = '{4'b0001, 32'd1,        32'd2,        5'd0, 0, 1, 6,  32'd1,        32'd3,        1, 4'b0101};
        vecs[5]  = '{4'b0010, 32'd10,       32'd20,       5'd0, 0, 0, 7,  32'd10,       32'd30,       0, 4'b0101};
        vecs[6]  = '{4'b0010, 32'd999,      32'd5,        5'd0, 1, 1, 8,  32'd30,       32'd35,       0, 4'b0000};
        vecs[7]  = '{4'b0011, 32'd100,      32'd0,        5'd0, 0, 0, 9,  32'd100,      32'd100,      1, 4'b0000};
        vecs[8]  = '{4'b0000, 32'd7,        32'd0,        5'd0, 1, 1, 10, 32'd100,      32'd100,      0, 4'b0000};
        vecs[9]  = '{4'b0101, 32'd0,        32'd1,        5'd0, 0, 1, 11, 32'd0,        32'hFFFFFFFF, 0, 4'b0010};
        vecs[10] = '{4'b0010, 32'h7FFFFFFF, 32'd1,        5'd0, 0, 1, 12, 32'h7FFFFFFF, 32'h80000000, 0, 4'b1010};
        vecs[11] = '{4'b1100, 32'd1,        32'd0,        5'd4, 0, 1, 13, 32'd1,        32'd16,       0, 4'b0000};
        vecs[12] = '{4'b1111, 32'd5,        32'd6,        5'd0, 0, 1, 14, 32'd5,        32'd11,       1, 4'b0000};
        vecs[13] = '{4'b1010, 32'hFFFF0000, 32'hFFFFFFFF, 5'd0, 0, 1, 31, 32'hFFFF0000, 32'h0000FFFF, 0, 4'b0000};

        rst        = 1'b1;
        rst2       = 1'b1;
        req_valid  = 1'b0;
        req_valid2 = 1'b0;
        rsp_ready  = 1'b1;
        rsp_ready2 = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        rst2 = 1'b0;
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset fu_a|fu_b|rsp_f", fu_a | fu_b | rsp_f, 32'd0);
        check("reset fs/sh/tag/err/sts",
              32'({fu_fs, fu_sh, rsp_tag, rsp_err, sts_v, sts_c, sts_n, sts_z}), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: response held for 6 cycles, competing request refused.
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(4'b0010, 32'd100, 32'd23, 5'd0, 1'b0, 1'b0, 5'd21);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("bp latency", 32'(cyc), 32'd2);
        check("bp rsp_f", rsp_f, 32'd123);
        held_f   = 32'd123;
        held_tag = 5'd21;
        drive(4'b1001, 32'd555, 32'd1, 5'd0, 1'b0, 1'b1, 5'd2);
        req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d rsp_f", k), rsp_f, held_f);
            check($sformatf("bp%0d rsp_tag", k), 32'(rsp_tag), 32'(held_tag));
            check($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("bp after rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp after req_ready", 32'(req_ready), 32'd1);
        check("bp fu_a not overwritten", fu_a, 32'd100);

        // Reset during EXEC on the FU_LAT=4 instance.
        drive(4'b0010, 32'd5, 32'd6, 5'd3, 1'b0, 1'b1, 5'd9);
        req_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid2 = 1'b0;
        @(negedge clk);
        check("lat4 fu_a before reset", fu_a2, 32'd5);
        check("lat4 req_ready in exec", 32'(req_ready2), 32'd0);
        rst2 = 1'b1;
        #1;
        check("lat4 reset fu_a|fu_b|rsp_f", fu_a2 | fu_b2 | rsp_f2, 32'd0);
        check("lat4 reset others",
              32'({fu_fs2, fu_sh2, rsp_tag2, rsp_err2, rsp_valid2,
                   sts_v2, sts_c2, sts_n2, sts_z2}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid2) seen++;
        end
        check("lat4 no response after reset", 32'(seen), 32'd0);
        check("lat4 req_ready after release", 32'(req_ready2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fu_op_sequencer.md
Name: fu_op_sequencer

Overview:
- Issuing end of the execute-stage function unit: accepts operation requests over a valid/ready handshake and drives the function unit's A, B, FS and SH inputs from registers.
- Waits a fixed settle latency, then samples the function unit's F, V, C, N and Z.
- Updates an architectural status register and returns the result over a second valid/ready handshake.
- Sits between the decode stage and the combinational function unit.

Parameters:
- FU_LAT, 1, cycles between the function-unit inputs becoming valid and result sampling; legal range 1..7.
- TAG_W, 5, width of the destination tag carried with each request.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_fs  in  4  function select code
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_sh  in  5  shift amount
- req_fwd_a  in  1  when 1, operand A is replaced by the last completed result
- req_setflags  in  1  when 1, the status register updates from this operation
- req_tag  in  TAG_W  destination tag, returned unchanged
- fu_a  out  32  registered operand A to the function unit
- fu_b  out  32  registered operand B to the function unit
- fu_fs  out  4  registered function select to the function unit
- fu_sh  out  5  registered shift amount to the function unit
- fu_f  in  32  function unit result
- fu_v, fu_c, fu_n, fu_z  in  1 each  function unit flags
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_f  out  32  captured result
- rsp_tag  out  TAG_W  tag of the completed operation
- rsp_err  out  1  function select code was illegal
- sts_v, sts_c, sts_n, sts_z  out  1 each  status register

Behaviour:
- Reset (asynchronous, takes effect immediately regardless of state):
  - state=IDLE, counter=0.
  - fu_a, fu_b, fu_fs, fu_sh, rsp_f, rsp_tag and the last-result register all =0.
  - rsp_valid=0, rsp_err=0, all sts_*=0.
  - req_ready=1 once rst deasserts.
  - Reset during EXEC or RESP discards the in-flight operation; no response is emitted.
- State IDLE:
  - req_ready=1.
  - On req_valid&req_ready: register fu_a (last result if req_fwd_a, else req_a), fu_b, fu_fs, fu_sh, tag and setflags; load counter=FU_LAT; go to EXEC.
- State EXEC:
  - req_ready=0.
  - Counter decrements each cycle.
  - On the cycle the counter is 1:
    - capture fu_f into rsp_f and the last-result register;
    - set rsp_err=1 if fu_fs is not one of 0000, 0010, 0101, 1000, 1001, 1010, 1011, 1100, 1101, 1110;
    - if setflags=1 and rsp_err=0, load sts_v/c/n/z from fu_v/c/n/z;
    - go to RESP.
  - fu_* outputs hold stable throughout EXEC.
- State RESP:
  - rsp_valid=1; rsp_f, rsp_tag and rsp_err hold stable while rsp_ready=0 (unbounded backpressure).
  - On rsp_ready=1: rsp_valid falls next cycle; go to IDLE.
  - No request is accepted in the same cycle the response is accepted.
- Latency and throughput:
  - Request acceptance to rsp_valid = FU_LAT+1 cycles.
  - Maximum throughput is one operation per FU_LAT+2 cycles.
- Illegal codes:
  - The result is still captured and returned.
  - The status register is untouched.
- Forwarding:
  - The last-result register holds the most recent captured F, including illegal-code results.
  - req_fwd_a on the first request after reset forwards 0.
- Stability rules:
  - fu_* outputs keep their values in IDLE and RESP (no toggling when idle).
  - req_* inputs are ignored outside IDLE.

Test Plan:
- FU_LAT=1, ADD (0010): a=5, b=7, setflags=1; model FU -> rsp_valid 2 cycles after acceptance, rsp_f=12, rsp_tag echoed, sts_z=0, rsp_err=0.
- SUB (0101): a=3, b=3, setflags=1 -> rsp_f=0, sts_z=1. Next op OR with setflags=0 -> status unchanged.
- Illegal code 0001: a=1, b=2, setflags=1 with status preloaded Z=1 -> rsp_err=1, sts_* unchanged.
- Forwarding: ADD 10+20, then ADD with req_fwd_a=1, b=5 -> second rsp_f=35, fu_a=30 during EXEC.
- Backpressure: hold rsp_ready=0 for 6 cycles -> rsp_valid, rsp_f and rsp_tag stable; req_ready=0 throughout; a new req_valid during this time is not accepted.
- Reset mid-EXEC with FU_LAT=4: assert rst during cycle 2 -> all outputs zero immediately, no rsp_valid afterwards, req_ready=1 after release.
